// File: rtl/ztex_nonce_queue_if.sv
// Signal bundle between hashcore/host pins and the ZTEX nonce queue.
// The master side drives hashcore results and host strobes; the slave is the queue.
interface ztex_nonce_queue_if;
    logic        gn_match;
    logic [31:0] golden_nonce;
    logic [31:0] nonce;
    logic        wr_start;
    logic        wr_clk;
    logic [7:0]  write;
    logic [4:0]  q_count;
    logic        q_overflow;

    modport master (
        output gn_match, golden_nonce, nonce, wr_start, wr_clk,
        input  write, q_count, q_overflow
    );

    modport slave (
        input  gn_match, golden_nonce, nonce, wr_start, wr_clk,
        output write, q_count, q_overflow
    );
endinterface

// File: rtl/ztex_nonce_queue.sv
// Golden-nonce FIFO feeding the ZTEX host: each host read-start loads a 12-byte
// frame that is shifted out LSB byte first, one byte per filtered wr_clk edge.
module ztex_nonce_queue #(
    parameter int          DEPTH = 4,
    parameter logic [15:0] MAGIC = 16'hA55A
) (
    input  logic               clk,
    input  logic               reset_n,
    ztex_nonce_queue_if.slave  bus
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL_CNT = 5'(DEPTH);

    // Async assert, sync release of the internal reset.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_int;

    logic [1:0]  start_sync_q, start_sync_d;
    logic [3:0]  start_hist_q, start_hist_d;
    logic [1:0]  clk_sync_q,   clk_sync_d;
    logic [3:0]  clk_hist_q,   clk_hist_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]  count_q,  count_d;
    logic [31:0] last_q,   last_d;
    logic [7:0]  drop_q,   drop_d;
    logic        ovf_q,    ovf_d;
    logic [95:0] frame_q,  frame_d;
    logic [7:0]  write_q,  write_d;
    logic [31:0] mem_q [DEPTH];

    logic        start_evt, shift_evt;
    logic        push_req, push, pop, drop;
    logic [31:0] head;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n_int = rst_sync_q[1];

    // Edge qualification on the synchronised host strobes.
    assign start_evt = start_hist_q[0] & ~start_hist_q[1];
    assign shift_evt = (clk_hist_q[3] == clk_hist_q[2]) &&
                       (clk_hist_q[2] == clk_hist_q[1]) &&
                       (clk_hist_q[1] != clk_hist_q[0]);

    assign push_req = bus.gn_match && (bus.golden_nonce != last_q);
    assign pop      = start_evt && (count_q != 5'd0);
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign push     = push_req && ((count_q != FULL_CNT) || pop);
    assign drop     = push_req && !push;
    assign head     = (count_q != 5'd0) ? mem_q[rd_ptr_q] : 32'h0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        start_sync_d = {start_sync_q[0], bus.wr_start};
        start_hist_d = {start_hist_q[2:0], start_sync_q[1]};
        clk_sync_d   = {clk_sync_q[0], bus.wr_clk};
        clk_hist_d   = {clk_hist_q[2:0], clk_sync_q[1]};
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_d       = last_q;
        drop_d       = drop_q;
        ovf_d        = ovf_q;
        frame_d      = frame_q;
        write_d      = frame_q[7:0];

        if (bus.gn_match) last_d = bus.golden_nonce;
        if (push)         wr_ptr_d = AW'(wr_ptr_q + 1'b1);
        if (pop)          rd_ptr_d = AW'(rd_ptr_q + 1'b1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end

        if (start_evt)      frame_d = {MAGIC, drop_q, 3'b000, count_q, bus.nonce, head};
        else if (shift_evt) frame_d = {8'h00, frame_q[95:8]};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            start_sync_q <= '0;
            start_hist_q <= '0;
            clk_sync_q   <= '0;
            clk_hist_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_q       <= '0;
            drop_q       <= '0;
            ovf_q        <= 1'b0;
            frame_q      <= '0;
            write_q      <= '0;
        end else begin
            start_sync_q <= start_sync_d;
            start_hist_q <= start_hist_d;
            clk_sync_q   <= clk_sync_d;
            clk_hist_q   <= clk_hist_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_q       <= last_d;
            drop_q       <= drop_d;
            ovf_q        <= ovf_d;
            frame_q      <= frame_d;
            write_q      <= write_d;
        end
    end

    // NOTE: storage is not reset; the occupancy counter decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.golden_nonce;
    end

    assign bus.write      = write_q;
    assign bus.q_count    = count_q;
    assign bus.q_overflow = ovf_q;
endmodule
